// File: rtl/dspl_mux_drv.sv
// dspl_mux_drv: multiplexed common-anode seven-segment driver.
// Scans N_DIGITS digits from a packed {en, val[3:0], dp} bus. Each digit slot
// is split into 16 brightness phases for global PWM dimming. Blinking is
// controlled per digit. Loads are double-buffered so that a displayed frame
// never mixes old and new data. A frame tick is produced once per full scan.
module dspl_mux_drv #(
    parameter int N_DIGITS     = 8,
    parameter int PHASE_CYCLES = 625,
    parameter int BLINK_FRAMES = 625
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [6*N_DIGITS-1:0]   digits,
    input  logic                    load,
    input  logic [N_DIGITS-1:0]     blink_mask,
    input  logic [3:0]              brightness,
    output logic [N_DIGITS-1:0]     an,
    output logic [7:0]              dec_ddp,
    output logic                    frame_tick
);

    localparam int CYC_W  = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;
    localparam int SLOT_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int BLK_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [CYC_W-1:0]    CYC_MAX  = CYC_W'(PHASE_CYCLES - 1);
    localparam logic [SLOT_W-1:0]   SLOT_MAX = SLOT_W'(N_DIGITS - 1);
    localparam logic [BLK_W-1:0]    BLK_MAX  = BLK_W'(BLINK_FRAMES - 1);
    localparam logic [N_DIGITS-1:0] AN_ONE   = N_DIGITS'(1);

    // Hex glyph table, active-low segments {a,b,c,d,e,f,g}.
    function automatic logic [6:0] f_glyph(input logic [3:0] val);
        logic [6:0] seg;
        case (val)
            4'h0:    seg = 7'b0000001;
            4'h1:    seg = 7'b1001111;
            4'h2:    seg = 7'b0010010;
            4'h3:    seg = 7'b0000110;
            4'h4:    seg = 7'b1001100;
            4'h5:    seg = 7'b0100100;
            4'h6:    seg = 7'b0100000;
            4'h7:    seg = 7'b0001111;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0000100;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b1100000;
            4'hC:    seg = 7'b0110001;
            4'hD:    seg = 7'b1000010;
            4'hE:    seg = 7'b0110000;
            default: seg = 7'b0111000;
        endcase
        return seg;
    endfunction

    // Scan counters and blink state.
    logic [CYC_W-1:0]        r_cyc;
    logic [3:0]              r_phase;
    logic [SLOT_W-1:0]       r_slot;
    logic [BLK_W-1:0]        r_blink_cnt;
    logic                    r_blink_phase;

    // Double buffer: shadow collects loads, active is what gets displayed.
    logic [6*N_DIGITS-1:0]   r_shadow;
    logic [6*N_DIGITS-1:0]   r_active;

    // Registered outputs, one cycle behind the counter state they decode.
    logic [N_DIGITS-1:0]     r_an_p1;
    logic [7:0]              r_dec_p1;
    logic                    r_tick_p1;

    logic                    w_cyc_max;
    logic                    w_phase_max;
    logic                    w_slot_max;
    logic                    w_frame_end;
    logic                    w_blink_wrap;
    logic [5:0]              w_digit;
    logic                    w_blink_sel;
    logic                    w_ghost;
    logic                    w_lit;
    logic [N_DIGITS-1:0]     w_an_nxt;
    logic [7:0]              w_dec_nxt;

    assign w_cyc_max    = (r_cyc == CYC_MAX);
    assign w_phase_max  = (r_phase == 4'hF);
    assign w_slot_max   = (r_slot == SLOT_MAX);
    assign w_frame_end  = w_cyc_max && w_phase_max && w_slot_max;
    assign w_blink_wrap = (r_blink_cnt == BLK_MAX);

    // Advance the cycle/phase/slot scan position, wrapping at each level.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_cyc   <= '0;
            r_phase <= '0;
            r_slot  <= '0;
        end else if (!w_cyc_max) begin
            r_cyc <= r_cyc + 1'b1;
        end else begin
            r_cyc <= '0;
            if (!w_phase_max) begin
                r_phase <= r_phase + 1'b1;
            end else begin
                r_phase <= '0;
                r_slot  <= w_slot_max ? '0 : r_slot + 1'b1;
            end
        end
    end

    // Count frames and flip the blink phase every BLINK_FRAMES frames.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
        end else if (w_frame_end) begin
            if (w_blink_wrap) begin
                r_blink_cnt   <= '0;
                r_blink_phase <= ~r_blink_phase;
            end else begin
                r_blink_cnt <= r_blink_cnt + 1'b1;
            end
        end
    end

    // Capture loads into the shadow buffer; promote the shadow to active only
    // at frame end, so a load in the frame-end cycle waits one more frame.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_shadow <= '0;
            r_active <= '0;
        end else begin
            if (w_frame_end)
                r_active <= r_shadow;
            if (load)
                r_shadow <= digits;
        end
    end

    // Select the digit under scan and its blink enable.
    always_comb begin
        w_digit     = '0;
        w_blink_sel = 1'b0;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (r_slot == SLOT_W'(i)) begin
                w_digit     = r_active[6*i +: 6];
                w_blink_sel = blink_mask[i];
            end
        end
    end

    // Decide whether the slot is lit. The first cycle of every slot is kept
    // dark so that the previous digit's segments do not ghost onto the new anode.
    always_comb begin
        w_ghost   = (r_cyc == '0) && (r_phase == 4'h0);
        w_lit     = w_digit[5] && (r_phase <= brightness) &&
                    !(w_blink_sel && r_blink_phase) && !w_ghost;
        w_an_nxt  = '1;
        w_dec_nxt = 8'hFF;
        if (w_lit) begin
            w_an_nxt  = ~(AN_ONE << r_slot);
            w_dec_nxt = {f_glyph(w_digit[4:1]), ~w_digit[0]};
        end
    end

    // ---- output register stage (p1) ----
    // Register the pin drivers and the frame tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_an_p1   <= '1;
            r_dec_p1  <= 8'hFF;
            r_tick_p1 <= 1'b0;
        end else begin
            r_an_p1   <= w_an_nxt;
            r_dec_p1  <= w_dec_nxt;
            r_tick_p1 <= w_frame_end;
        end
    end

    assign an         = r_an_p1;
    assign dec_ddp    = r_dec_p1;
    assign frame_tick = r_tick_p1;

endmodule
